// File: rtl/whack_button_conditioner_if.sv
// Press-event handshake between the button conditioner and the game core.
// The producer raises evt_valid with a stable index until the consumer acks.
interface whack_button_conditioner_if #(
    parameter int NUM_BTN = 4
);
    localparam int IDX_W = $clog2(NUM_BTN);

    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_multi;
    logic             evt_ack;

    modport master (
        output evt_valid,
        output evt_idx,
        output evt_multi,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        input  evt_multi,
        output evt_ack
    );
endinterface

// File: rtl/whack_button_conditioner.sv
// Whack-a-mole button front end: per-button synchronizer, counter debouncer,
// rising-edge detect and a one-entry press-event register with overflow.
module whack_button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_raw,
    output logic [NUM_BTN-1:0]         btn_level,
    whack_button_conditioner_if.master evt,
    output logic                       overflow,
    input  logic                       clear_overflow
);
    localparam int IDX_W = $clog2(NUM_BTN);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] rise;
    logic [IDX_W-1:0]   rise_idx;
    logic               rise_multi;
    logic               rise_any;
    logic               evt_valid_q;
    logic [IDX_W-1:0]   evt_idx_q;
    logic               evt_multi_q;
    logic               accept;
    logic               drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        // Any sample agreeing with the current level restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync_q2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl <= sync_q2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign btn_level[i] = lvl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= btn_level;
        end
    end

    always_comb begin
        rise     = btn_level & ~level_q;
        rise_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                rise_idx = IDX_W'(i);
            end
        end
        // Clearing the lowest set bit leaves something only if two or more rose.
        rise_multi = |(rise & (rise - NUM_BTN'(1)));
        rise_any   = |rise;
        accept     = rise_any && (!evt_valid_q || evt.evt_ack);
        drop       = rise_any && evt_valid_q && !evt.evt_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            evt_multi_q <= 1'b0;
        end else if (accept) begin
            evt_valid_q <= 1'b1;
            evt_idx_q   <= rise_idx;
            evt_multi_q <= rise_multi;
        end else if (evt.evt_ack) begin
            evt_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_idx   = evt_idx_q;
    assign evt.evt_multi = evt_multi_q;
endmodule

// File: doc/whack_button_conditioner.md
Name: whack_button_conditioner

Overview:
Input-side front end for the whack-a-mole game: takes the raw, asynchronous player buttons that the game core reads and turns them into clean press events. Per button it provides a 2-flop synchronizer, a counter debouncer and rising-edge detection. Press events go into a one-entry event register with a valid/ack handshake toward the game core, plus sticky overflow reporting.

Parameters:
NUM_BTN, 4, number of player buttons (2..8)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles needed to accept a level change (1 ms at 1 MHz); minimum 2
IDX_W, derived = clog2(NUM_BTN), width of the event index (localparam, not overridable)

Ports:
clk  input  1  system clock, 1 MHz nominal
rst  input  1  synchronous, active-high reset
btn_raw  input  NUM_BTN  raw button levels, asynchronous, 1 = pressed
btn_level  output  NUM_BTN  debounced button levels
evt_valid  output  1  press event pending
evt_idx  output  IDX_W  index of the pressed button (lowest index wins)
evt_multi  output  1  more than one button rose in the same cycle
evt_ack  input  1  consumer accepts the pending event
overflow  output  1  sticky: a press event was dropped
clear_overflow  input  1  clears overflow

Behaviour:
- Reset (rst=1 at a clk edge): synchronizer flops, debounce counters, btn_level, evt_valid, evt_idx, evt_multi and overflow all go to 0. Reset mid-debounce or with an event pending discards all state. A button held through reset registers as a press once it has been debounced after reset.
- Synchronizer: two flops per bit; sync = second flop. Inputs are never used before the second flop.
- Debounce, per bit, counter of width clog2(DEBOUNCE_CYCLES):
  - sync == btn_level: counter <= 0.
  - sync != btn_level and counter < DEBOUNCE_CYCLES-1: counter++.
  - sync != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= sync, counter <= 0.
  - Any glitch back to the old level before acceptance restarts the count from 0.
- Latency: a clean raw edge changes btn_level exactly 2 + DEBOUNCE_CYCLES clk edges later.
- Rise mask: bits where btn_level goes 0->1 on a given edge. Releases never generate events.
- Event register: loads on the edge after the rise mask is non-zero.
  - evt_idx = lowest set bit of the rise mask.
  - evt_multi = popcount(rise mask) > 1.
  - evt_valid = 1.
- Handshake:
  - evt_valid stays high, and evt_idx/evt_multi stay stable, until an edge where evt_ack=1. That edge clears evt_valid.
  - evt_ack while evt_valid=0 is ignored.
  - New rise in the same cycle as an ack: the new event loads and evt_valid stays 1 (no bubble).
  - New rise while evt_valid=1 and evt_ack=0: the new event is dropped, the pending one is kept, and overflow <= 1.
- Overflow:
  - Cleared by clear_overflow=1 on an edge.
  - Set and clear in the same cycle: set wins.

Test Plan:
(Simulation uses DEBOUNCE_CYCLES=8, NUM_BTN=4.)
- Reset check: hold rst=1 for 3 cycles with btn_raw=4'b1111 -> all outputs 0. Release rst -> btn_level=4'b1111 exactly 10 cycles later; evt_valid=1, evt_idx=0, evt_multi=1 on the following cycle.
- Clean press: btn_raw[2] rises at cycle 0 -> btn_level[2]=1 at cycle 10, evt_valid=1 with evt_idx=2 at cycle 11. Pulse evt_ack at cycle 15 -> evt_valid=0 at cycle 16. Releasing btn_raw[2] -> no event.
- Bounce rejection: toggle btn_raw[1] with a 3-cycle period for 30 cycles, then hold high -> btn_level[1] rises exactly 10 cycles after the final toggle, and exactly one event is produced.
- Simultaneous press: btn_raw[3] and btn_raw[1] rise on the same cycle -> one event with evt_idx=1, evt_multi=1.
- Overflow: press btn 0 and leave it unacked, then press btn 3 -> evt_idx remains 0, overflow=1. Assert clear_overflow -> overflow=0 next cycle. Assert clear_overflow together with a new dropped press -> overflow stays 1.
- Back-to-back: btn 3's rise lands on the same cycle as evt_ack for btn 0's event -> evt_valid never drops; evt_idx changes 0 -> 3.
